// File: rtl/bram_arb_pkg.sv
// Shared defaults, width helpers and types for the program-BRAM read arbiter.
// Read words are RATIO narrow write words wide.
package bram_arb_pkg;

  localparam int N_REQ_DEFAULT            = 32'sd4;
  localparam int READ_WIDTH_DEFAULT       = 32'sd64;
  localparam int READ_ADDR_WIDTH_DEFAULT  = 32'sd9;
  localparam int WRITE_WIDTH_DEFAULT      = 32'sd32;
  localparam int WRITE_ADDR_WIDTH_DEFAULT = 32'sd10;

  // Ceiling log2; log2(1) = 0 so a 1:1 port ratio needs no lane bits.
  function automatic int log2(input int value);
    int result;
    int pow;
    result = 32'sd0;
    pow    = 32'sd1;
    while (pow < value) begin
      pow    = pow * 32'sd2;
      result = result + 32'sd1;
    end
    return result;
  endfunction

  localparam int RATIO      = READ_WIDTH_DEFAULT / WRITE_WIDTH_DEFAULT;
  localparam int LOG2_RATIO = log2(RATIO);

  typedef logic [N_REQ_DEFAULT-1:0] grant_t;

endpackage

// File: rtl/bram.sv
// Asymmetric simple-dual-port program RAM: narrow write port, wide read port,
// one-cycle registered read. Contents are not reset.
module bram #(
  parameter int READ_WIDTH       = bram_arb_pkg::READ_WIDTH_DEFAULT,
  parameter int READ_ADDR_WIDTH  = bram_arb_pkg::READ_ADDR_WIDTH_DEFAULT,
  parameter int WRITE_WIDTH      = bram_arb_pkg::WRITE_WIDTH_DEFAULT,
  parameter int WRITE_ADDR_WIDTH = bram_arb_pkg::WRITE_ADDR_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        w_valid,
  input  logic [WRITE_ADDR_WIDTH-1:0] w_addr,
  input  logic [WRITE_WIDTH-1:0]      w_data,
  input  logic                        r_valid,
  input  logic [READ_ADDR_WIDTH-1:0]  r_addr,
  output logic [READ_WIDTH-1:0]       r_data
);
  import bram_arb_pkg::*;

  localparam int RD_SHIFT = log2(READ_WIDTH / WRITE_WIDTH);
  localparam int DEPTH    = 32'sd1 << READ_ADDR_WIDTH;

  logic [READ_WIDTH-1:0] mem_r [DEPTH];
  logic [READ_WIDTH-1:0] r_data_r;

  generate
    if (RD_SHIFT == 32'sd0) begin : g_full_word
      // Write port as wide as the read port: whole-word write.
      always_ff @(posedge clk) begin
        if (w_valid) begin
          mem_r[w_addr] <= w_data;
        end
      end
    end else begin : g_lane_write
      // Narrow write lands in lane w_addr[RD_SHIFT-1:0] of its read word.
      always_ff @(posedge clk) begin
        if (w_valid) begin
          mem_r[w_addr[WRITE_ADDR_WIDTH-1:RD_SHIFT]][w_addr[RD_SHIFT-1:0]*WRITE_WIDTH +: WRITE_WIDTH] <= w_data;
        end
      end
    end
  endgenerate

  // Registered read; output holds when no read is issued.
  always_ff @(posedge clk) begin
    if (r_valid) begin
      r_data_r <= mem_r[r_addr];
    end else begin
      r_data_r <= r_data_r;
    end
  end

  assign r_data = r_data_r;

endmodule

// File: rtl/bram_arb_param_check.sv
// Elaboration-time consistency checks on the arbiter/BRAM width parameters.
// Elaborates to nothing when the parameters are consistent.
module bram_arb_param_check #(
  parameter int N_REQ            = bram_arb_pkg::N_REQ_DEFAULT,
  parameter int READ_WIDTH       = bram_arb_pkg::READ_WIDTH_DEFAULT,
  parameter int READ_ADDR_WIDTH  = bram_arb_pkg::READ_ADDR_WIDTH_DEFAULT,
  parameter int WRITE_WIDTH      = bram_arb_pkg::WRITE_WIDTH_DEFAULT,
  parameter int WRITE_ADDR_WIDTH = bram_arb_pkg::WRITE_ADDR_WIDTH_DEFAULT
) ();
  import bram_arb_pkg::*;

  localparam int RD_RATIO = READ_WIDTH / WRITE_WIDTH;
  localparam int RD_SHIFT = log2(RD_RATIO);

  generate
    if (N_REQ < 32'sd1) begin : g_bad_n_req
      $error("bram_read_arbiter: N_REQ must be at least 1");
    end
    if (READ_WIDTH != RD_RATIO * WRITE_WIDTH) begin : g_bad_ratio
      $error("bram_read_arbiter: READ_WIDTH must be a multiple of WRITE_WIDTH");
    end
    if ((32'sd1 << RD_SHIFT) != RD_RATIO) begin : g_bad_pow2
      $error("bram_read_arbiter: width ratio must be a power of 2");
    end
    if (WRITE_ADDR_WIDTH != READ_ADDR_WIDTH + RD_SHIFT) begin : g_bad_addr
      $error("bram_read_arbiter: WRITE_ADDR_WIDTH must be READ_ADDR_WIDTH + log2(ratio)");
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ     = bram_arb_pkg::N_REQ_DEFAULT,
  parameter int PTR_WIDTH = 32'sd2
) (
  input  logic [N_REQ-1:0]     eligible,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]     grant,
  output logic [PTR_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  // Scan ptr, ptr+1, ... (mod N_REQ); the first hit wins.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx_s;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_s     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx_s = PTR_WIDTH'((int'(ptr) + off) % N_REQ);
      if (!grant_any && eligible[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        grant_any    = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin arbitration of the program BRAM read port among N_REQ requesters,
// with same-cycle write hazards masked so a granted read never returns stale data.
module bram_read_arbiter #(
  parameter int N_REQ            = bram_arb_pkg::N_REQ_DEFAULT,
  parameter int READ_WIDTH       = bram_arb_pkg::READ_WIDTH_DEFAULT,
  parameter int READ_ADDR_WIDTH  = bram_arb_pkg::READ_ADDR_WIDTH_DEFAULT,
  parameter int WRITE_WIDTH      = bram_arb_pkg::WRITE_WIDTH_DEFAULT,
  parameter int WRITE_ADDR_WIDTH = bram_arb_pkg::WRITE_ADDR_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*READ_ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 resp_valid,
  output logic [READ_WIDTH-1:0]            resp_data,
  input  logic                             wr_valid,
  input  logic [WRITE_ADDR_WIDTH-1:0]      wr_addr,
  input  logic [WRITE_WIDTH-1:0]           wr_data
);
  import bram_arb_pkg::*;

  localparam int RD_SHIFT  = log2(READ_WIDTH / WRITE_WIDTH);
  localparam int PTR_WIDTH = (N_REQ > 32'sd1) ? $clog2(N_REQ) : 32'sd1;

  logic [PTR_WIDTH-1:0]       ptr_r;
  logic [PTR_WIDTH-1:0]       ptr_nxt_s;
  logic [N_REQ-1:0]           tag_r;
  logic [N_REQ-1:0]           eligible_s;
  logic [N_REQ-1:0]           grant_s;
  logic [PTR_WIDTH-1:0]       grant_idx_s;
  logic                       grant_any_s;
  logic [READ_ADDR_WIDTH-1:0] wr_word_s;
  logic [READ_ADDR_WIDTH-1:0] r_addr_s;
  logic                       r_valid_s;
  logic [READ_WIDTH-1:0]      r_data_s;

  bram_arb_param_check #(
    .N_REQ(N_REQ), .READ_WIDTH(READ_WIDTH), .READ_ADDR_WIDTH(READ_ADDR_WIDTH),
    .WRITE_WIDTH(WRITE_WIDTH), .WRITE_ADDR_WIDTH(WRITE_ADDR_WIDTH)
  ) u_param_check ();

  assign wr_word_s = wr_addr[WRITE_ADDR_WIDTH-1:RD_SHIFT];

  // A requester colliding with this cycle's write is skipped, retrying next cycle.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_valid && (req_addr[i*READ_ADDR_WIDTH +: READ_ADDR_WIDTH] == wr_word_s)) begin
        eligible_s[i] = 1'b0;
      end else begin
        eligible_s[i] = req_valid[i];
      end
    end
  end

  rr_arbiter #(.N_REQ(N_REQ), .PTR_WIDTH(PTR_WIDTH)) u_rr (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .grant_idx(grant_idx_s),
    .grant_any(grant_any_s)
  );

  // One-hot address mux, next-pointer and reset gating of the handshake outputs.
  always_comb begin
    r_addr_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        r_addr_s = req_addr[i*READ_ADDR_WIDTH +: READ_ADDR_WIDTH];
      end else begin
        r_addr_s = r_addr_s;
      end
    end
    if (!grant_any_s) begin
      ptr_nxt_s = ptr_r;
    end else if (grant_idx_s == PTR_WIDTH'(N_REQ - 32'sd1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_idx_s + PTR_WIDTH'(1);
    end
    if (rst) begin
      req_ready  = '0;
      resp_valid = '0;
      r_valid_s  = 1'b0;
    end else begin
      req_ready  = grant_s;
      resp_valid = tag_r;
      r_valid_s  = grant_any_s;
    end
  end

  // Pointer and grant-tag state; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
      tag_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
      tag_r <= grant_s;
    end
  end

  bram #(
    .READ_WIDTH(READ_WIDTH), .READ_ADDR_WIDTH(READ_ADDR_WIDTH),
    .WRITE_WIDTH(WRITE_WIDTH), .WRITE_ADDR_WIDTH(WRITE_ADDR_WIDTH)
  ) u_bram (
    .clk    (clk),
    .w_valid(wr_valid),
    .w_addr (wr_addr),
    .w_data (wr_data),
    .r_valid(r_valid_s),
    .r_addr (r_addr_s),
    .r_data (r_data_s)
  );

  assign resp_data = r_data_s;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Scoreboard bench for bram_read_arbiter: directed scenarios then random traffic,
// checked against a word-array memory model and a round-robin grant model.
module tb_bram_read_arbiter;

  localparam int N   = 4;
  localparam int RAW = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req_valid = 4'd0;
  logic [35:0]    req_addr = 36'd0;
  logic [3:0]     req_ready;
  logic [3:0]     resp_valid;
  logic [63:0]    resp_data;
  logic           wr_valid = 1'b0;
  logic [9:0]     wr_addr = 10'd0;
  logic [31:0]    wr_data = 32'd0;

  always #5 clk = ~clk;

  bram_read_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  onehot;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mdl [512];
  int          mdl_ptr = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [35:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
  endfunction

  // One clock cycle of stimulus plus the reference model's view of it.
  task automatic step(input logic r, input logic [3:0] v, input logic [35:0] a,
                      input logic wv, input logic [9:0] wa, input logic [31:0] wd);
    logic [3:0] g;
    int         gi;
    exp_t       e;
    @(negedge clk);
    cyc++;
    rst = r; req_valid = v; req_addr = a; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
    g  = 4'd0;
    gi = -1;
    if (r) begin
      if (q.size() > 0 && q[q.size()-1].cyc == cyc - 1) void'(q.pop_back());
      mdl_ptr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i = (mdl_ptr + k) % N;
        bit haz = wv && (int'(wa) / 2 == int'(a[i*RAW +: RAW]));
        if (gi < 0 && v[i] && !haz) gi = i;
      end
      if (gi >= 0) begin
        g[gi]    = 1'b1;
        e.cyc    = cyc;
        e.onehot = g;
        e.data   = mdl[int'(a[gi*RAW +: RAW])];
        q.push_back(e);
        mdl_ptr  = (gi + 1) % N;
      end
    end
    check("req_ready", 64'(req_ready), 64'(g));
    if (wv) mdl[int'(wa[9:1])][int'(wa[0])*32 +: 32] = wd;
  endtask

  // Monitor: a grant in cycle c must surface as exactly one response in cycle c+1.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (resp_valid !== 4'd0) begin
        if (q.size() > 0 && q[0].cyc == cyc - 1) begin
          e = q.pop_front();
          check("resp_valid", 64'(resp_valid), 64'(e.onehot));
          check("resp_data", resp_data, e.data);
        end else begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected cyc=%0d got=%h expected=0", cyc, resp_valid);
        end
      end else if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL resp_missing cyc=%0d got=0 expected=%h", cyc, e.onehot);
      end
    end
  end

  initial begin
    logic [35:0] a;
    logic [9:0]  wa;
    int          k;

    step(1'b1, 4'd0, 36'd0, 1'b0, 10'd0, 32'd0);
    step(1'b1, 4'd0, 36'd0, 1'b0, 10'd0, 32'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    for (int w = 0; w < 64; w++) step(1'b0, 4'd0, 36'd0, 1'b1, 10'(w), $urandom);

    // Load two narrow words and read them back as one wide word.
    step(1'b0, 4'd0, 36'd0, 1'b1, 10'd10, 32'hAAAA_0001);
    step(1'b0, 4'd0, 36'd0, 1'b1, 10'd11, 32'hBBBB_0002);
    step(1'b0, 4'b0001, pack(5, 0, 0, 0), 1'b0, 10'd0, 32'd0);

    // Fairness from reset, then wrap-and-skip with only 3 and 0 valid.
    step(1'b1, 4'd0, 36'd0, 1'b0, 10'd0, 32'd0);
    for (int c = 0; c < 7; c++) step(1'b0, 4'hF, pack(5, 6, 7, 8), 1'b0, 10'd0, 32'd0);
    step(1'b0, 4'b1001, pack(5, 6, 7, 8), 1'b0, 10'd0, 32'd0);
    step(1'b0, 4'b1001, pack(5, 6, 7, 8), 1'b0, 10'd0, 32'd0);

    // Hazard: req 0 collides with the write, req 1 wins, req 0 then sees new data.
    step(1'b1, 4'd0, 36'd0, 1'b0, 10'd0, 32'd0);
    step(1'b0, 4'b0011, pack(10, 3, 0, 0), 1'b1, 10'd20, 32'h0000_1234);
    step(1'b0, 4'b0001, pack(10, 3, 0, 0), 1'b0, 10'd0, 32'd0);

    // Streaming by a single requester.
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0100, pack(0, 0, i, 0), 1'b0, 10'd0, 32'd0);

    // Reset right after a grant, then lowest valid index wins.
    step(1'b0, 4'b0001, pack(1, 0, 0, 0), 1'b0, 10'd0, 32'd0);
    step(1'b1, 4'hF, pack(1, 2, 3, 4), 1'b0, 10'd0, 32'd0);
    step(1'b0, 4'b1110, pack(0, 2, 3, 4), 1'b0, 10'd0, 32'd0);

    // Random traffic with frequent forced hazards and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      a = pack($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) wa = {a[k*RAW +: RAW], 1'($urandom_range(0, 1))};
      else wa = 10'($urandom_range(0, 63));
      step(1'($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), a,
           1'($urandom_range(0, 1)), wa, $urandom);
    end

    for (int c = 0; c < 3; c++) step(1'b0, 4'd0, 36'd0, 1'b0, 10'd0, 32'd0);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
